seg7_scan_bcd: RTL

//  Parametrised 7-segment scan driver for ADC readings: accepts a DATA_W-bit sample plus channel via valid/ready,

---
 rtl/seg7_scan_bcd_if.sv | 12 +
 rtl/seg7_scan_bcd.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_bcd_if.sv
// Sample handshake between the ADC reader (master) and the 7-segment scan driver (slave).
interface seg7_scan_bcd_if #(
    parameter int DATA_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_channel;

    modport master (output in_valid, output in_data, output in_channel, input in_ready);
    modport slave  (input in_valid, input in_data, input in_channel, output in_ready);
endinterface

// File: rtl/seg7_scan_bcd.sv
// 7-segment scan driver: sequential binary-to-BCD conversion of an ADC sample,
// then time-multiplexed "CH<n> <value>" across NUM_DIGITS active-low digit selects.
module seg7_scan_bcd #(
    parameter int DATA_W     = 10,
    parameter int VAL_DIGITS = 4,
    parameter int NUM_DIGITS = 4 + VAL_DIGITS,
    parameter int SCAN_DIV_W = 13,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    seg7_scan_bcd_if.slave        smp,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] seg7_x,
    output logic [7:0]            seg7_y
);
    localparam int BCD_W = 4 * VAL_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   shift_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [BCD_W-1:0]    bcd_adj;
    logic [2:0]          ch_hold;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BCD_W-1:0]    disp_bcd;
    logic [2:0]          disp_ch;

    logic [SCAN_DIV_W-1:0] presc;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic [VAL_DIGITS-1:0] blank;
    logic [7:0]            digit_pat;
    logic [NUM_DIGITS-1:0] x_next;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 8'hFC;
            4'd1:    seg_of = 8'h60;
            4'd2:    seg_of = 8'hDA;
            4'd3:    seg_of = 8'hF2;
            4'd4:    seg_of = 8'h66;
            4'd5:    seg_of = 8'hB6;
            4'd6:    seg_of = 8'hBE;
            4'd7:    seg_of = 8'hE4;
            4'd8:    seg_of = 8'hFE;
            4'd9:    seg_of = 8'hF6;
            default: seg_of = 8'hFC;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < VAL_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // in_ready is 1 exactly while IDLE, so a valid in IDLE is a completed handshake.
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            smp.in_ready <= 1'b1;
            busy         <= 1'b0;
            shift_q      <= '0;
            bcd_q        <= '0;
            ch_hold      <= '0;
            bit_cnt      <= '0;
            disp_bcd     <= '0;
            disp_ch      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (smp.in_valid) begin
                        state        <= CONVERT;
                        smp.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        shift_q      <= smp.in_data;
                        ch_hold      <= smp.in_channel;
                        bcd_q        <= '0;
                        bit_cnt      <= '0;
                    end
                end
                CONVERT: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    bit_cnt          <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    disp_bcd     <= bcd_q;
                    disp_ch      <= ch_hold;
                    state        <= IDLE;
                    smp.in_ready <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    smp.in_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    assign tick = &presc;

    // A value digit is blank while every more significant digit is also zero.
    always_comb begin
        logic lead;
        blank = '0;
        lead  = 1'b1;
        for (int unsigned j = VAL_DIGITS - 1; j >= 1; j--) begin
            if (lead && (disp_bcd[4*j +: 4] == 4'd0))
                blank[j] = BLANK_LZ;
            else
                lead = 1'b0;
        end
    end

    always_comb begin
        digit_pat = 8'h00;
        case (idx)
            IDX_W'(0): digit_pat = 8'h9C;
            IDX_W'(1): digit_pat = 8'h6E;
            IDX_W'(2): digit_pat = seg_of({1'b0, disp_ch} + 4'd1);
            IDX_W'(3): digit_pat = 8'h00;
            default: begin
                for (int unsigned j = 0; j < VAL_DIGITS; j++) begin
                    if (idx == IDX_W'(NUM_DIGITS - 1 - j))
                        digit_pat = blank[j] ? 8'h00 : seg_of(disp_bcd[4*j +: 4]);
                end
            end
        endcase
    end

    always_comb begin
        x_next = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            x_next[i] = (IDX_W'(NUM_DIGITS - 1 - i) != idx);
    end

    // idx names the digit shown at the next tick, so the first tick after reset shows digit 0.
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            idx    <= '0;
            seg7_x <= '1;
            seg7_y <= 8'hFF;
        end else begin
            presc <= presc + 1'b1;
            if (tick) begin
                seg7_x <= x_next;
                seg7_y <= ACTIVE_LOW ? ~digit_pat : digit_pat;
                idx    <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end
endmodule
